// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants for the VGA display path and the
// sprite controllers that consume hCount/vCount/bright.
package vga_pkg;

    localparam int unsigned COUNT_W = 10;

    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;

    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;

    function automatic int unsigned axis_total(input int unsigned sync, input int unsigned back,
                                               input int unsigned visible,
                                               input int unsigned front);
        return sync + back + visible + front;
    endfunction

    localparam int unsigned H_TOTAL = axis_total(VGA_H_SYNC, VGA_H_BACK, VGA_H_VISIBLE,
                                                 VGA_H_FRONT);
    localparam int unsigned V_TOTAL = axis_total(VGA_V_SYNC, VGA_V_BACK, VGA_V_VISIBLE,
                                                 VGA_V_FRONT);

    // Top-left corner of the visible window, shared with the sprite controllers.
    localparam int unsigned H_ORIGIN = VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned V_ORIGIN = VGA_V_SYNC + VGA_V_BACK;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with enable, registered active-low sync and a
// next-state active-window flag so the parent can register a combined bright.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL     = H_TOTAL,
    parameter int unsigned SYNC      = VGA_H_SYNC,
    parameter int unsigned ACT_START = H_ORIGIN,
    parameter int unsigned ACT_END   = H_ORIGIN + VGA_H_VISIBLE - 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_sync_n,
    output logic               o_active_nxt,
    output logic               o_wrap
);

    localparam logic [COUNT_W-1:0] L_LAST  = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] L_SYNC  = COUNT_W'(SYNC);
    localparam logic [COUNT_W-1:0] L_ACT_S = COUNT_W'(ACT_START);
    localparam logic [COUNT_W-1:0] L_ACT_E = COUNT_W'(ACT_END);

    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count_nxt;
    logic               r_sync_n;
    logic               w_sync_n_nxt;
    logic               w_wrap;
    logic               w_active_nxt;

    // >= rather than == so a corrupted out-of-range count recovers on the next enable.
    always_comb begin
        w_wrap      = i_en && (r_count >= L_LAST);
        w_count_nxt = r_count;
        if (i_en) begin
            w_count_nxt = (r_count >= L_LAST) ? '0 : r_count + 1'b1;
        end
        w_sync_n_nxt = !(w_count_nxt < L_SYNC);
        w_active_nxt = (w_count_nxt >= L_ACT_S) && (w_count_nxt <= L_ACT_E);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count  <= '0;
            r_sync_n <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_sync_n <= w_sync_n_nxt;
        end
    end

    assign o_count      = r_count;
    assign o_sync_n     = r_sync_n;
    assign o_active_nxt = w_active_nxt;
    assign o_wrap       = w_wrap;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical counters and
// registered sync, bright and line/frame strobes, all updating on the same clk edge.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT   = VGA_V_FRONT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               pix_en,
    output logic [COUNT_W-1:0] hCount,
    output logic [COUNT_W-1:0] vCount,
    output logic               hSync,
    output logic               vSync,
    output logic               bright,
    output logic               line_tick,
    output logic               frame_tick
);

    localparam int unsigned      DIV_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] L_DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic [DIV_W-1:0] r_div;
    logic             r_pix_en;
    logic             r_bright;
    logic             r_line_tick;
    logic             r_frame_tick;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_h_act_nxt;
    logic             w_v_act_nxt;

    // Assert asynchronously, release two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= (r_div == L_DIV_LAST) ? '0 : r_div + 1'b1;
            r_pix_en <= (r_div == L_DIV_LAST);
        end
    end

    vga_axis_counter #(
        .TOTAL    (axis_total(H_SYNC, H_BACK, H_VISIBLE, H_FRONT)),
        .SYNC     (H_SYNC),
        .ACT_START(H_SYNC + H_BACK),
        .ACT_END  (H_SYNC + H_BACK + H_VISIBLE - 1)
    ) u_h_axis (
        .i_clk       (clk),
        .i_rst_n     (w_rst_n),
        .i_en        (r_pix_en),
        .o_count     (hCount),
        .o_sync_n    (hSync),
        .o_active_nxt(w_h_act_nxt),
        .o_wrap      (w_h_wrap)
    );

    vga_axis_counter #(
        .TOTAL    (axis_total(V_SYNC, V_BACK, V_VISIBLE, V_FRONT)),
        .SYNC     (V_SYNC),
        .ACT_START(V_SYNC + V_BACK),
        .ACT_END  (V_SYNC + V_BACK + V_VISIBLE - 1)
    ) u_v_axis (
        .i_clk       (clk),
        .i_rst_n     (w_rst_n),
        .i_en        (w_h_wrap),
        .o_count     (vCount),
        .o_sync_n    (vSync),
        .o_active_nxt(w_v_act_nxt),
        .o_wrap      (w_v_wrap)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bright     <= 1'b0;
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_bright     <= w_h_act_nxt && w_v_act_nxt;
            r_line_tick  <= w_h_wrap;
            r_frame_tick <= w_v_wrap;
        end
    end

    assign pix_en     = r_pix_en;
    assign bright     = r_bright;
    assign line_tick  = r_line_tick;
    assign frame_tick = r_frame_tick;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the 640x480 VGA display path. It divides the 100 MHz system clock to a 25 MHz pixel rate and runs the horizontal and vertical counters. From those counters it produces the `hCount`/`vCount`/`bright` stream that the sprite controllers (e.g. `rex_control`) consume, plus the active-low sync pulses that go to the connector. It is the driving end of the `hCount`/`vCount`/`bright` interface; every per-pixel renderer sits downstream of it.

## Interface
- `CLK_DIV`, 4: system clocks per pixel (power of two, ≥2)
- `H_SYNC`, 96: hsync pulse width, pixels
- `H_BACK`, 48: horizontal back porch
- `H_VISIBLE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch
- `V_SYNC`, 2: vsync pulse width, lines
- `V_BACK`, 33: vertical back porch
- `V_VISIBLE`, 480: visible lines
- `V_FRONT`, 10: vertical front porch
- `clk` input 1: system clock, 100 MHz
- `rst_n` input 1: asynchronous, active-low reset; one clock domain only
- `pix_en` output 1: one-`clk` strobe, once every `CLK_DIV` clocks; counters advance on it
- `hCount` output 10: horizontal position, 0..H_TOTAL-1 (800)
- `vCount` output 10: vertical position, 0..V_TOTAL-1 (525)
- `hSync` output 1: active-low horizontal sync
- `vSync` output 1: active-low vertical sync
- `bright` output 1: high inside the visible window
- `line_tick` output 1: one-`clk` pulse on the edge where `hCount` wraps to 0
- `frame_tick` output 1: one-`clk` pulse on the edge where both counters wrap to 0

## Operation
- Derived constants: H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525.
- Line layout: sync at 0..95, back porch at 96..143, visible at 144..783, front porch at 784..799. Frame layout follows the same order: sync at 0..1, visible at 35..514, front porch at 515..524.
- Divider: a 2-bit counter `div` runs 0..CLK_DIV-1. `pix_en` is registered high for the single clock where `div` wraps.
- Horizontal counter, on each `pix_en`:
  - `hCount` increments.
  - At H_TOTAL-1 it wraps to 0 and `vCount` increments.
- Vertical counter: at V_TOTAL-1 together with the horizontal wrap, `vCount` wraps to 0.
- Decode:
  - `hSync` = !(hCount < H_SYNC).
  - `vSync` = !(vCount < V_SYNC).
  - `bright` = hCount in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1] and vCount in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE-1].
- All outputs are registered. Decode is computed from the next-state counter values, so the decoded outputs change on the same `clk` edge as the counters with zero skew.
- Counter values outside the valid range cannot occur. If an out-of-range value is detected anyway, the counter wraps to 0 on the next `pix_en`.

## Timing
- Reset values:
  - `div`=0, `pix_en`=0.
  - `hCount`=0, `vCount`=0.
  - `hSync`=0 and `vSync`=0, because counter position 0 lies inside the sync pulse.
  - `bright`=0, `line_tick`=0, `frame_tick`=0.
- First `pix_en` after reset release: on the CLK_DIV-th rising `clk` edge. `hCount` becomes 1 on the edge after that `pix_en`.
- Each counter value is held for exactly CLK_DIV clocks, and all outputs are stable for that whole interval.
- Line period: 3200 `clk`. Frame period: 1,680,000 `clk`.
- `line_tick` and `frame_tick` are asserted in the same clock that `hCount` becomes 0. At the frame wrap both are high in the same clock.
- `frame_tick` marks the start of vsync. Game logic updates positions on it so that every position change lands outside the visible window.
- Reset mid-frame: all outputs go to their reset values asynchronously. Release is synchronised with a 2-flop reset synchroniser, so de-assertion takes effect 2 `clk` after `rst_n` rises. Downstream logic sees a fresh frame starting at (0,0).

## Structure
- Shared package `vga_pkg`:
  - H_/V_ timing constants and H_TOTAL/V_TOTAL.
  - The visible-window origin (144, 35), which sprite controllers also use.
  - COUNT_W = 10.
- Natural sub-module: `vga_axis_counter`, a wrap counter with enable plus sync/active-window decode. Instantiate it twice, horizontal (enable = `pix_en`) and vertical (enable = horizontal wrap). It outputs its wrap strobe.

## Test plan
- Reset, then release; count 4 clocks → `pix_en` pulses at clk 4 and 8; `hCount` 0→1→2; `hSync`=0, `bright`=0.
- Run one line → `hSync` low for exactly 96×4=384 clk. `bright` first rises when `hCount`=144 and `vCount`=35, and stays high for 640×4=2560 clk. `line_tick` period is 3200 clk.
- Run one full frame → `vSync` low for 2 lines (6400 clk). Exactly 480 lines contain `bright`. `frame_tick` period is 1,680,000 clk, coincident with `hCount`=`vCount`=0.
- At (799, 524) → the next `pix_en` edge gives (0,0), `line_tick`=`frame_tick`=1 for one clk, and `hSync`/`vSync` fall on that same edge.
- Assert `rst_n`=0 at (400, 200) for 3 clk → outputs go to reset values immediately. The first `pix_en` occurs 2+4 clk after release.
- Attach a `rex_control` instance with its box at (450, 250) → the red 11×11 box is captured in a frame dump. Pixels with `bright`=0 are black.
